// File: rtl/ddr3_rw_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller user port between a write and a read requester.
// One command per granted burst, beat counting to completion, with abort on de-init or a stalled handshake.
module ddr3_rw_arbiter #(
  parameter int ADDR_WIDTH     = 28,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  ddrc_init_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  output logic                  wr_grant,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_grant,
  output logic                  rd_done,
  output logic                  ddr_cmd_valid,
  input  logic                  ddr_cmd_ready,
  output logic                  ddr_cmd_write,
  output logic [ADDR_WIDTH-1:0] ddr_cmd_addr,
  output logic [LEN_WIDTH-1:0]  ddr_cmd_len,
  input  logic                  ddr_wr_data_req,
  input  logic                  ddr_rd_data_valid,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                state, state_next;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  rr_last_write;

  logic load_cmd, sel_write, beat;
  logic clr_beat, inc_beat, clr_to, inc_to, set_err, upd_rr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  // Only the owning direction's strobe counts as a beat.
  assign beat = cmd_write ? ddr_wr_data_req : ddr_rd_data_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load_cmd   = 1'b0;
    sel_write  = 1'b0;
    clr_beat   = 1'b0;
    inc_beat   = 1'b0;
    clr_to     = 1'b0;
    inc_to     = 1'b0;
    set_err    = 1'b0;
    upd_rr     = 1'b0;
    case (state)
      IDLE: begin
        if (ddrc_init_done && (wr_req || rd_req)) begin
          sel_write  = wr_req && (!rd_req || !rr_last_write);
          load_cmd   = 1'b1;
          clr_to     = 1'b1;
          state_next = CMD;
        end
      end
      CMD: begin
        if (!ddrc_init_done) begin
          state_next = IDLE;
        end else if (ddr_cmd_ready) begin
          clr_beat   = 1'b1;
          clr_to     = 1'b1;
          state_next = DATA;
        end else if (to_cnt == TO_LAST) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else begin
          inc_to = 1'b1;
        end
      end
      DATA: begin
        if (!ddrc_init_done) begin
          state_next = IDLE;
        end else if (beat) begin
          clr_to = 1'b1;
          if (beat_cnt == cmd_len) state_next = DONE;
          else                     inc_beat   = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else begin
          inc_to = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        upd_rr     = ddrc_init_done;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_write     <= 1'b0;
      cmd_addr      <= '0;
      cmd_len       <= '0;
      beat_cnt      <= '0;
      to_cnt        <= '0;
      rr_last_write <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      if (load_cmd) begin
        cmd_write <= sel_write;
        cmd_addr  <= sel_write ? wr_addr : rd_addr;
        cmd_len   <= sel_write ? wr_len  : rd_len;
      end
      if (clr_beat)      beat_cnt <= '0;
      else if (inc_beat) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      if (clr_to)        to_cnt   <= '0;
      else if (inc_to)   to_cnt   <= to_cnt + TW'(1);
      if (set_err)       timeout_err   <= 1'b1;
      if (upd_rr)        rr_last_write <= cmd_write;
    end
  end

  // A de-init landing in DONE suppresses the done pulse along with the rest of the burst.
  assign busy          = (state != IDLE);
  assign wr_grant      = busy && cmd_write;
  assign rd_grant      = busy && !cmd_write;
  assign wr_done       = (state == DONE) && cmd_write && ddrc_init_done;
  assign rd_done       = (state == DONE) && !cmd_write && ddrc_init_done;
  assign ddr_cmd_valid = (state == CMD);
  assign ddr_cmd_write = cmd_write;
  assign ddr_cmd_addr  = cmd_addr;
  assign ddr_cmd_len   = cmd_len;

endmodule

// File: doc/ddr3_rw_arbiter.md
Name: ddr3_rw_arbiter

Overview:
- Arbitrates the single DDR3 controller user port between one write requester and one read requester (the user data send/receive paths).
- Grants one burst at a time and issues one command per burst.
- Counts data beats until the burst completes, then returns done to the granted requester.
- Alternates round-robin when both request, and aborts on controller de-initialisation or a stalled handshake.

Parameters:
ADDR_WIDTH, 28, width of DDR3 user address.
LEN_WIDTH, 8, burst length field width; field value = beats-1 (0 = 1 beat, 255 = 256 beats).
TIMEOUT_CYCLES, 1023, max cycles without progress in CMD/DATA before abort (fits 10 bits; counter width $clog2(TIMEOUT_CYCLES+1)).

Ports:
sys_clk  in  1  single clock, all logic rising-edge.
sys_rst_n  in  1  asynchronous active-low reset.
ddrc_init_done  in  1  controller ready; arbitration only when high.
wr_req  in  1  write requester level request.
wr_addr  in  ADDR_WIDTH  write burst start address (sampled at grant).
wr_len  in  LEN_WIDTH  write beats-1 (sampled at grant).
wr_grant  out  1  high while write burst owns the port.
wr_done  out  1  one-cycle pulse, write burst finished.
rd_req  in  1  read requester level request.
rd_addr  in  ADDR_WIDTH  read burst start address.
rd_len  in  LEN_WIDTH  read beats-1.
rd_grant  out  1  high while read burst owns the port.
rd_done  out  1  one-cycle pulse, read burst finished.
ddr_cmd_valid  out  1  command valid.
ddr_cmd_ready  in  1  controller accepts command when valid&ready.
ddr_cmd_write  out  1  1 = write, 0 = read.
ddr_cmd_addr  out  ADDR_WIDTH  latched address.
ddr_cmd_len  out  LEN_WIDTH  latched beats-1.
ddr_wr_data_req  in  1  controller consumed one write beat this cycle.
ddr_rd_data_valid  in  1  controller delivered one read beat this cycle.
busy  out  1  state != IDLE.
timeout_err  out  1  sticky; set on timeout abort, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat/timeout counters 0; rr_last_write = 0 (write wins the first tie).
- States: IDLE, CMD, DATA, DONE.
- IDLE:
  - If ddrc_init_done and (wr_req|rd_req), select a winner and go to CMD.
  - Only one requesting: it wins.
  - Both requesting: write wins if rr_last_write=0, else read.
  - On the transition, latch addr/len/direction into ddr_cmd_* registers; the selected grant rises the same edge.
  - Requests are ignored while init_done is low.
- CMD:
  - ddr_cmd_valid=1; cmd fields stable.
  - On valid&ready: clear beat counter and go to DATA (valid low next cycle).
- DATA:
  - Count beats: ddr_wr_data_req if write, ddr_rd_data_valid if read; the other direction's strobe is ignored.
  - Beat while count == latched len: go to DONE.
  - Beat count width is LEN_WIDTH; no wrap is possible.
- DONE (1 cycle):
  - Pulse wr_done or rd_done.
  - Grant drops at the exit edge (grant high CMD..DONE inclusive).
  - rr_last_write <= direction just served.
  - Next state IDLE.
  - Requester deasserts req on seeing done if no further burst.
  - IDLE re-arbitrates on the cycle after DONE, so back-to-back bursts have a minimum 1 idle cycle.
- Latency:
  - req high in IDLE → cmd_valid next cycle.
  - Last beat → done next cycle.
- Timeout:
  - Counter runs in CMD/DATA; cleared on state entry, command handshake or any counted beat.
  - At TIMEOUT_CYCLES: set timeout_err, go to DONE (done still pulses so requester unblocks), drop cmd_valid.
- init_done falls in CMD/DATA/DONE:
  - Next edge → IDLE.
  - cmd_valid and grants cleared; no done pulse; rr pointer unchanged; timeout_err unaffected.
- Changes to addr/len after grant have no effect.
- Async reset mid-burst: immediate return to reset values.

Test Plan:
- Single write: init_done=1, wr_req with wr_addr=0x100, wr_len=3, ready=1, 4 wr_data_req pulses. Required: cmd_valid one cycle with write=1, addr=0x100, len=3; wr_done one cycle after 4th beat; wr_grant 0 after.
- Tie round-robin: wr_req and rd_req held high, each burst len=0. Required: grant order W,R,W,R; one idle cycle between bursts.
- Cmd backpressure: rd_req, ddr_cmd_ready low 20 cycles then high. Required: cmd_valid held 21 cycles with stable addr/len; no timeout.
- Wrong-direction strobe: read burst len=1; ddr_wr_data_req pulses interleaved with 2 rd_data_valid. Required: rd_done only after 2 rd_data_valid.
- Timeout: write granted, ready=1, no wr_data_req for 1023 cycles. Required: timeout_err=1 sticky, wr_done pulse, return to IDLE.
- init_done drop: in DATA after 2 of 8 beats, deassert init_done. Required: IDLE next cycle, grant 0, no done; reassert init_done with req held → new command.
